// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: register-index width
// and the FSM state encoding.
package hazard_ctrl_pkg;
  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_REDIRECT   = 2'd3
  } state_t;
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              r_cnt <= '0;
    else if (i_clr)            r_cnt <= '0;
    else if (i_inc && ~&r_cnt) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, EX redirect flushes and
// data-memory wait holds, sequenced by a small Mealy FSM.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_is_load,
  input  logic             i_ex_redirect,
  input  logic             i_mem_busy,
  output logic             o_pc_hold,
  output logic             o_ifid_hold,
  output logic             o_ifid_flush,
  output logic             o_idex_bubble,
  output logic             o_pipe_hold,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_stall_cnt
);
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TO_M1      = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [1:0]        FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  state_t r_state, w_state_nxt;
  logic [1:0] r_flush_cnt, w_flush_nxt;
  logic r_resume, w_resume_nxt;
  logic r_mem_err;
  logic w_lu;
  logic w_hold, w_flush, w_bubble, w_pipe;
  logic [WAIT_W-1:0] w_wait_cnt;

  assign w_lu = i_ex_is_load && (i_ex_rd != '0) &&
                ((i_id_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
                 (i_id_use_rs2 && (i_id_rs2 == i_ex_rd)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
      r_resume    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_nxt;
      r_resume    <= w_resume_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_flush_nxt  = r_flush_cnt;
    w_resume_nxt = r_resume;
    case (r_state)
      ST_RUN: begin
        if (i_mem_busy) begin
          w_state_nxt  = ST_MEM_WAIT;
          w_resume_nxt = 1'b0;
        end else if (i_ex_redirect) begin
          if (FLUSH_CYCLES > 1) begin
            w_state_nxt = ST_REDIRECT;
            w_flush_nxt = FLUSH_INIT;
          end
        end else if (w_lu) begin
          w_state_nxt = ST_LOAD_STALL;
        end
      end
      ST_LOAD_STALL: w_state_nxt = ST_RUN;
      ST_MEM_WAIT: begin
        if (!i_mem_busy) begin
          w_state_nxt  = r_resume ? ST_REDIRECT : ST_RUN;
          w_resume_nxt = 1'b0;
        end
      end
      ST_REDIRECT: begin
        // a memory wait preempts the flush; the saved bit brings us back here
        if (i_mem_busy) begin
          w_state_nxt  = ST_MEM_WAIT;
          w_resume_nxt = 1'b1;
        end else begin
          w_flush_nxt = r_flush_cnt - 2'd1;
          if (r_flush_cnt <= 2'd1) w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_hold   = 1'b0;
    w_flush  = 1'b0;
    w_bubble = 1'b0;
    w_pipe   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_mem_busy) begin
          w_hold = 1'b1;
          w_pipe = 1'b1;
        end else if (i_ex_redirect) begin
          w_flush  = 1'b1;
          w_bubble = 1'b1;
        end else if (w_lu) begin
          w_hold   = 1'b1;
          w_bubble = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        w_hold = i_mem_busy;
        w_pipe = i_mem_busy;
      end
      ST_REDIRECT: begin
        w_hold   = i_mem_busy;
        w_pipe   = i_mem_busy;
        w_flush  = !i_mem_busy;
        w_bubble = !i_mem_busy;
      end
      default: ;
    endcase
  end

  // gate with reset so a mid-cycle assert silences the Mealy outputs at once
  assign o_pc_hold     = i_rst_n & w_hold;
  assign o_ifid_hold   = i_rst_n & w_hold;
  assign o_ifid_flush  = i_rst_n & w_flush;
  assign o_idex_bubble = i_rst_n & w_bubble;
  assign o_pipe_hold   = i_rst_n & w_pipe;

  // counts consecutive busy cycles regardless of which state is holding
  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (!i_mem_busy),
    .i_inc  (i_mem_busy),
    .o_cnt  (w_wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (1'b0),
    .i_inc  (o_pc_hold),
    .o_cnt  (o_stall_cnt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                  r_mem_err <= 1'b0;
    else if (i_mem_busy && (w_wait_cnt >= TO_M1))  r_mem_err <= 1'b1;
  end

  assign o_mem_err = r_mem_err;
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Upstream-facing counterpart to the ID/EX control register: it decides each cycle whether that register captures new control, holds, or receives a bubble.
- It also drives hold and flush for PC and IF/ID.
- It detects load-use hazards, EX-stage redirects (taken branch or jump) and multi-cycle data-memory waits, and sequences the resulting stalls and flushes with a small FSM.
- It sits beside the decoder in the five-stage pipeline.

Parameters:
- FLUSH_CYCLES, 1: number of cycles IF/ID is flushed after a redirect (1..3).
- MEM_TIMEOUT, 15: mem_busy cycles tolerated before mem_err is raised.
- CNT_W, 16: width of the stall performance counter.

Ports:
- CLK  in  1  pipeline clock; FSM state is updated on posedge.
- RST_n  in  1  asynchronous, active-low reset.
- id_rs1  in  5  rs1 index of the instruction in ID.
- id_rs2  in  5  rs2 index of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_is_load  in  1  EX instruction is a load.
- ex_redirect  in  1  EX resolved a taken branch or jump.
- mem_busy  in  1  data memory has not completed its access this cycle.
- pc_hold  out  1  PC keeps its value.
- ifid_hold  out  1  IF/ID keeps its contents.
- ifid_flush  out  1  IF/ID is loaded with a NOP.
- idex_bubble  out  1  ID/EX control inputs are forced to zero (DataWr=0, no register write).
- pipe_hold  out  1  ID/EX, EX/MEM and MEM/WB hold.
- mem_err  out  1  sticky flag: memory wait exceeded MEM_TIMEOUT.
- stall_cnt  out  CNT_W  count of cycles in which pc_hold was 1; saturates at all-ones.

Behaviour:
- Reset: while RST_n=0, state=RUN, flush counter=0, wait counter=0, mem_err=0, stall_cnt=0, and every output is 0. Reset is asynchronous and takes effect mid-stall; no pending flush survives it.
- Outputs are combinational (Mealy) from state and current inputs, so a stall applies in the cycle the hazard is detected. Counters and state change on posedge CLK only.
- Load-use hazard (lu): ex_is_load=1 and ex_rd!=0, and either (id_use_rs1=1 and id_rs1==ex_rd) or (id_use_rs2=1 and id_rs2==ex_rd).
- Priority within a cycle: mem_busy, then ex_redirect, then lu.
- RUN state:
  - mem_busy=1: assert pc_hold, ifid_hold and pipe_hold; go to MEM_WAIT; wait counter=1.
  - Else ex_redirect=1: assert ifid_flush and idex_bubble. If FLUSH_CYCLES>1, go to REDIRECT with flush counter=FLUSH_CYCLES-1; otherwise stay in RUN.
  - Else lu=1: assert pc_hold, ifid_hold and idex_bubble for exactly one cycle; go to LOAD_STALL.
  - Else: all outputs 0.
- LOAD_STALL state: all outputs 0 (the load has moved to MEM; forwarding covers the dependency). Return to RUN. A new lu in this cycle is not possible because the bubble is in EX.
- MEM_WAIT state:
  - While mem_busy=1: pc_hold, ifid_hold and pipe_hold stay 1; wait counter increments. When wait counter reaches MEM_TIMEOUT, set mem_err=1; it stays set until reset. The stall continues regardless.
  - When mem_busy=0: outputs 0; return to RUN; wait counter=0.
  - A redirect or lu pending during the wait is evaluated in RUN afterwards, because the pipeline was frozen and inputs are unchanged.
- REDIRECT state:
  - Assert ifid_flush and idex_bubble; decrement the flush counter; go to RUN when it reaches 0.
  - mem_busy=1 here takes priority: hold as in MEM_WAIT, flush counter frozen, then resume REDIRECT afterwards. Track this with a saved-state bit.
- ifid_hold and ifid_flush are never both 1; flush wins by construction.
- stall_cnt increments on every posedge where pc_hold=1 and stall_cnt is not all-ones.

Decomposition:
- Shared pipeline package: state encoding constants (RUN=2'd0, LOAD_STALL=2'd1, MEM_WAIT=2'd2, REDIRECT=2'd3) and the register-index width (5).
- One natural sub-module: sat_counter, a saturating counter parameterised by width, instantiated for stall_cnt and for the wait counter.

Test Plan:
1. Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle with pc_hold=ifid_hold=idex_bubble=1, next cycle all 0; stall_cnt=1.
2. Load to x0: ex_is_load=1, ex_rd=0, id_rs1=0, id_use_rs1=1 -> no stall; all outputs 0.
3. Redirect with FLUSH_CYCLES=2: ex_redirect=1 for one cycle -> ifid_flush=idex_bubble=1 for 2 consecutive cycles, then 0.
4. Simultaneous: mem_busy=1, ex_redirect=1 and lu=1 in one cycle, mem_busy held 3 cycles -> 3 cycles of pipe_hold=pc_hold=1, then redirect flush; lu is not asserted afterwards because the redirect bubble removes it; stall_cnt=3.
5. Timeout: mem_busy held 16 cycles with MEM_TIMEOUT=15 -> mem_err rises on the 15th posedge and stays 1 after mem_busy drops; cleared only by RST_n=0.
6. Reset mid-REDIRECT: drive RST_n low asynchronously between clock edges -> all outputs 0 immediately; after release, no residual flush occurs.
